// File: rtl/operand_feeder.sv
// operand_feeder: FIFO-buffered operand source for the 8-bit sequence accumulator.
// Each start issues BURST_LEN operands, one per clock, framed by an acc_clear
// pulse before the burst and a burst_done pulse on the last operand.
// Optional: define STALL_CNT_EN to add the stall_count output, which counts
// bubble cycles in RUN and saturates at 255.
module operand_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  output logic             acc_clear,
  output logic             burst_done,
  output logic             busy
`ifdef STALL_CNT_EN
  ,
  output logic [7:0]       stall_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [7:0]    BURST_LAST = 8'(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [7:0]       issue_cnt;
  logic [7:0]       issue_d;
  logic [7:0]       issue_inc;
  logic             push;
  logic             pop;
  logic             acc_clear_d;
  logic             burst_done_d;
`ifdef STALL_CNT_EN
  logic [7:0]       stall_d;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, FIFO handshake and next values of the registered outputs
  always_comb begin
    push         = in_valid && in_ready;
    pop          = (state == S_RUN) && (count != '0);
    state_d      = state;
    issue_d      = issue_cnt;
    issue_inc    = issue_cnt + 8'd1;
    acc_clear_d  = 1'b0;
    burst_done_d = 1'b0;
`ifdef STALL_CNT_EN
    stall_d      = stall_count;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          acc_clear_d = 1'b1;
        end
      end
      S_CLEAR: begin
        issue_d = 8'd0;
        state_d = S_RUN;
`ifdef STALL_CNT_EN
        stall_d = 8'd0;
`endif
      end
      S_RUN: begin
        if (pop) begin
          issue_d = issue_inc;
          if (issue_inc == BURST_LAST) begin
            state_d      = S_DONE;
            burst_done_d = 1'b1;
          end
        end else begin
`ifdef STALL_CNT_EN
          if (stall_count != 8'hFF) stall_d = stall_count + 8'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // FIFO pointers, occupancy, burst counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      issue_cnt  <= 8'd0;
      in_ready   <= 1'b1;
      a_out      <= '0;
      a_valid    <= 1'b0;
      acc_clear  <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
`ifdef STALL_CNT_EN
      stall_count <= 8'd0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_d;
      issue_cnt  <= issue_d;
      in_ready   <= (count_d != FULL_CNT);
      a_out      <= pop ? mem[rd_ptr] : '0;
      a_valid    <= pop;
      acc_clear  <= acc_clear_d;
      burst_done <= burst_done_d;
      busy       <= (state_d != S_IDLE);
`ifdef STALL_CNT_EN
      stall_count <= stall_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
